// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//
// Pipeline stage register with a valid/ready handshake and a two-entry skid
// buffer. One instance sits between each pair of stages (F/D, D/E, E/M, M/W).
//
// The stage holds a "main" entry, which drives the outputs, and a "skid" entry.
// The skid entry catches a payload that arrives while the main entry is stalled.
// Because in_ready is derived only from the skid-valid flop, there is no
// combinational path from out_ready back to in_ready. Long pipes therefore
// never form a ready chain through the stages.
//
// Parameters
//   DATA_W          payload width in bits
//   CLEAR_ON_FLUSH  1: payload registers are zeroed on flush
//                   0: only the valid bits are cleared (reset always zeroes)
//   CNT_W           width of the saturating bubble counter
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-low reset (0 = reset)
//   in_valid    upstream presents a payload
//   in_ready    stage can accept (registered, equals !skid_valid)
//   in_data     upstream payload
//   flush       synchronous kill of all held entries; any input offered in
//               the same cycle is dropped
//   out_valid   main entry holds a payload
//   out_ready   downstream accepts this cycle
//   out_data    payload of the main entry
//   bubble_cnt  count of cycles with out_ready=1 and out_valid=0 (saturating)
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int DATA_W         = 193,
    parameter int CLEAR_ON_FLUSH = 1,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Main entry: drives the outputs.
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    // Skid entry: holds the second payload while the main entry is stalled.
    logic              s_valid;
    logic [DATA_W-1:0] s_data;

    logic              m_valid_nx;
    logic [DATA_W-1:0] m_data_nx;
    logic              s_valid_nx;
    logic [DATA_W-1:0] s_data_nx;

    logic              acc;
    logic              pop;

    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign in_ready  = !s_valid;

    assign acc = in_valid & in_ready;
    assign pop = m_valid & out_ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        m_valid_nx = m_valid;
        m_data_nx  = m_data;
        s_valid_nx = s_valid;
        s_data_nx  = s_data;

        if (flush) begin
            // Flush overrides both acc and pop. A payload offered this cycle
            // is dropped even though in_ready may be high.
            m_valid_nx = 1'b0;
            s_valid_nx = 1'b0;
            if (CLEAR_ON_FLUSH != 0) begin
                m_data_nx = '0;
                s_data_nx = '0;
            end
        end else if (pop) begin
            if (s_valid) begin
                // Skid drains into main. acc cannot occur here because
                // in_ready is low whenever the skid entry is valid.
                m_data_nx  = s_data;
                s_valid_nx = 1'b0;
            end else if (acc) begin
                // Full-throughput pass: main is replaced in the same cycle.
                m_data_nx = in_data;
            end else begin
                // Stale m_data is kept; only the valid bit drops.
                m_valid_nx = 1'b0;
            end
        end else if (acc) begin
            if (!m_valid) begin
                m_valid_nx = 1'b1;
                m_data_nx  = in_data;
            end else begin
                // Main is stalled, so park the payload. in_ready drops next cycle.
                s_valid_nx = 1'b1;
                s_data_nx  = in_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_data  <= '0;
            s_data  <= '0;
        end else begin
            m_valid <= m_valid_nx;
            s_valid <= s_valid_nx;
            m_data  <= m_data_nx;
            s_data  <= s_data_nx;
        end
    end

    // -------------------------------------------------------------------------
    // Bubble counter: downstream was ready but the stage had nothing to give.
    // The counter still counts during a flush and saturates instead of wrapping.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            bubble_cnt <= '0;
        end else if (out_ready && !m_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Drives two instances of pipe_stage_skid from shared stimulus. Both use
// DATA_W=32 and CNT_W=3.
//   dut_a: CLEAR_ON_FLUSH=1
//   dut_b: CLEAR_ON_FLUSH=0
//
// The reference model is a payload queue of depth 2. The front of the queue is
// the visible payload, and in_ready is "fewer than two held". The model also
// keeps a last-shown value per instance, because out_data keeps its last value
// while the queue is empty. Directed literal checks pin the model at the
// points worked out by hand below.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

    localparam int DW = 32;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          iv;
    logic [DW-1:0] din;
    logic          fl;
    logic          ordy;

    logic          ir_a, ov_a, ir_b, ov_b;
    logic [DW-1:0] od_a, od_b;
    logic [CW-1:0] bc_a, bc_b;

    int tests = 0;
    int fails = 0;

    // Model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] hold_a;
    logic [DW-1:0] hold_b;
    int            bub;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .CLEAR_ON_FLUSH(1), .CNT_W(CW)) dut_a (
        .clk(clk), .reset(rst), .in_valid(iv), .in_ready(ir_a), .in_data(din),
        .flush(fl), .out_valid(ov_a), .out_ready(ordy), .out_data(od_a),
        .bubble_cnt(bc_a)
    );

    pipe_stage_skid #(.DATA_W(DW), .CLEAR_ON_FLUSH(0), .CNT_W(CW)) dut_b (
        .clk(clk), .reset(rst), .in_valid(iv), .in_ready(ir_b), .in_data(din),
        .flush(fl), .out_valid(ov_b), .out_ready(ordy), .out_data(od_b),
        .bubble_cnt(bc_b)
    );

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Advances the model by one rising edge, using the inputs currently driven.
    task automatic model_step();
        bit pop, acc;
        if (!rst) begin
            q.delete();
            hold_a = '0;
            hold_b = '0;
            bub    = 0;
        end else begin
            if (ordy && q.size() == 0 && bub < (1 << CW) - 1) bub++;
            if (fl) begin
                q.delete();
                hold_a = '0;
            end else begin
                pop = ordy && (q.size() > 0);
                acc = iv && (q.size() < 2);
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(din);
            end
            if (q.size() > 0) begin
                hold_a = q[0];
                hold_b = q[0];
            end
        end
    endtask

    task automatic check_all();
        logic [DW-1:0] ev, er;
        ev = (q.size() > 0) ? 1 : 0;
        er = (q.size() < 2) ? 1 : 0;
        chk("out_valid_a", {31'd0, ov_a}, ev);
        chk("out_valid_b", {31'd0, ov_b}, ev);
        chk("in_ready_a",  {31'd0, ir_a}, er);
        chk("in_ready_b",  {31'd0, ir_b}, er);
        chk("out_data_a",  od_a, hold_a);
        chk("out_data_b",  od_b, hold_b);
        chk("bubble_a",    {29'd0, bc_a}, DW'(bub));
        chk("bubble_b",    {29'd0, bc_b}, DW'(bub));
    endtask

    // One clock cycle: drive the inputs, step the model across the posedge,
    // then compare every output on the following negedge.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r,
                       input logic f, input logic n_rst);
        iv = v; din = d; ordy = r; fl = f; rst = n_rst;
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        iv = 0; din = '0; ordy = 0; fl = 0; rst = 0;

        // Reset
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_ov",  {31'd0, ov_a}, 0);
        chk("rst_od",  od_a, 0);
        chk("rst_ir",  {31'd0, ir_a}, 1);
        chk("rst_bub", {29'd0, bc_a}, 0);

        // Streaming 1..4 with out_ready high
        for (int i = 1; i <= 4; i++) begin
            cyc(1, DW'(i), 1, 0, 1);
            chk("stream_od", od_a, DW'(i));
            chk("stream_ov", {31'd0, ov_a}, 1);
            chk("stream_ir", {31'd0, ir_a}, 1);
        end
        cyc(0, 0, 1, 0, 1);
        chk("stream_end_ov", {31'd0, ov_a}, 0);

        // Backpressure
        cyc(1, 32'hA, 0, 0, 1);
        chk("bp_od1", od_a, 32'hA);
        chk("bp_ir1", {31'd0, ir_a}, 1);
        cyc(1, 32'hB, 0, 0, 1);
        chk("bp_od2", od_a, 32'hA);
        chk("bp_ir2", {31'd0, ir_a}, 0);
        cyc(1, 32'hC, 0, 0, 1);            // refused: in_ready is low
        chk("bp_hold_od", od_a, 32'hA);
        chk("bp_hold_ir", {31'd0, ir_a}, 0);
        cyc(0, 0, 1, 0, 1);
        chk("bp_pop_od", od_a, 32'hB);
        chk("bp_pop_ir", {31'd0, ir_a}, 1);
        cyc(0, 0, 1, 0, 1);
        chk("bp_empty_ov", {31'd0, ov_a}, 0);

        // Flush while full, with a simultaneous input
        cyc(1, 32'h11, 0, 0, 1);
        cyc(1, 32'h22, 0, 0, 1);
        chk("full_ir", {31'd0, ir_a}, 0);
        cyc(1, 32'h33, 0, 1, 1);
        chk("fl_ov_a", {31'd0, ov_a}, 0);
        chk("fl_od_a", od_a, 0);
        chk("fl_ir_a", {31'd0, ir_a}, 1);
        chk("fl_od_b", od_b, 32'h11);
        cyc(0, 0, 1, 0, 1);
        chk("fl_no33_ov", {31'd0, ov_a}, 0);

        // Flush with CLEAR_ON_FLUSH=0 keeps the payload visible
        cyc(1, 32'h55, 0, 0, 1);
        chk("keep_od_b", od_b, 32'h55);
        cyc(0, 0, 0, 1, 1);
        chk("keep_ov_b", {31'd0, ov_b}, 0);
        chk("keep_od_b2", od_b, 32'h55);
        chk("keep_od_a", od_a, 0);

        // Bubble counter saturation
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 1);
        chk("bub_sat", {29'd0, bc_a}, 7);
        cyc(0, 0, 1, 0, 0);
        chk("bub_rst", {29'd0, bc_a}, 0);
        cyc(0, 0, 1, 0, 1);
        chk("bub_one", {29'd0, bc_a}, 1);

        // Reset mid-stream while full, then resume
        cyc(1, 32'h66, 0, 0, 1);
        cyc(1, 32'h77, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("mrst_ov", {31'd0, ov_b}, 0);
        chk("mrst_od", od_b, 0);
        chk("mrst_ir", {31'd0, ir_b}, 1);
        cyc(1, 32'h8, 1, 0, 1);
        chk("resume_od1", od_a, 32'h8);
        cyc(1, 32'h9, 1, 0, 1);
        chk("resume_od2", od_a, 32'h9);

        // Mixed traffic; the model checks every cycle
        for (int i = 0; i < 80; i++)
            cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 15) == 0), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
